alu_muldiv_seq: RTL

Multi-cycle sequencer that runs unsigned 32x32 multiply (MULU) and unsigned 32/32 divide (DIVU) on the core's shared 32-bit ALU. It does one shift-add or shift-subtract step per cycle. While busy it drives the ALU operand and function inputs, and it raises alu_sel so the core steers the ALU to it. It sits beside the execute stage and stalls the pipeline via busy until done.

---
 rtl/alu_muldiv_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// -----------------------------------------------------------------------------
// alu_muldiv_seq
//
// Multi-cycle unsigned 32x32 multiply (MULU) and 32/32 divide (DIVU) sequencer
// that borrows the core's shared 32-bit ALU. One shift-add (multiply) or
// restoring shift-subtract (divide) step is performed per RUN cycle, for 32
// cycles. The ALU carry-out is not exported, so it is reconstructed here from
// the operand and result sign bits.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, op, a, b     request (sampled in IDLE), 0=MULU 1=DIVU, operands
//   busy, done          busy while an operation is in flight, 1-cycle done
//   result_hi/lo        MULU: product[63:32]/[31:0]; DIVU: remainder/quotient
//   alu_sel             core steers ALU inputs from this block while high
//   alu_x, alu_y        ALU operands
//   alu_add_sub         0=add, 1=subtract
//   alu_logic_fn        constant LOGIC_FN_IDLE
//   alu_fn_class        constant FN_ARITH
//   alu_result          combinational ALU result of alu_x/alu_y
// -----------------------------------------------------------------------------
module alu_muldiv_seq #(
    parameter logic [1:0] FN_ARITH      = 2'b10,
    parameter logic [1:0] LOGIC_FN_IDLE = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic        alu_sel,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic        alu_add_sub,
    output logic [1:0]  alu_logic_fn,
    output logic [1:0]  alu_fn_class,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [31:0] hi_q, hi_d;        // MULU: product high half; DIVU: remainder
    logic [31:0] lo_q, lo_d;        // MULU: multiplier/product low; DIVU: quotient
    logic [31:0] mcand_q, mcand_d;  // MULU: multiplicand; DIVU: divisor
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        alu_sel_q, alu_sel_d;
    logic [31:0] alu_x_q, alu_x_d;
    logic [31:0] alu_y_q, alu_y_d;
    logic        alu_sub_q, alu_sub_d;

    logic        add_carry_s;
    logic        sub_nb_s;
    logic        qbit_s;

    // Next-state, datapath step and next values of all registered outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        qbit_s    = 1'b0;

        // Carry / no-borrow recovered from sign bits of x, y and the ALU result.
        add_carry_s = (alu_x_q[31] & alu_y_q[31]) |
                      ((alu_x_q[31] | alu_y_q[31]) & ~alu_result[31]);
        sub_nb_s    = (alu_x_q[31] & ~alu_y_q[31]) |
                      ((alu_x_q[31] | ~alu_y_q[31]) & ~alu_result[31]);

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = 5'd31;
                    if (op && (b == 32'd0)) begin
                        state_d  = DONE;
                        mcand_d  = b;
                        res_lo_d = 32'hFFFF_FFFF;
                        res_hi_d = a;
                    end else begin
                        state_d = RUN;
                        hi_d    = 32'd0;
                        lo_d    = op ? a : b;
                        mcand_d = op ? b : a;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!op_q) begin
                    hi_d = {add_carry_s, alu_result[31:1]};
                    lo_d = {alu_result[0], lo_q[31:1]};
                end else begin
                    // hi_q[31] is the bit shifted out of the 33-bit partial
                    // remainder; when set, the subtraction always fits.
                    qbit_s = hi_q[31] | sub_nb_s;
                    hi_d   = qbit_s ? alu_result : alu_x_q;
                    lo_d   = {lo_q[30:0], qbit_s};
                end
                if (cnt_q == 5'd0) begin
                    state_d  = DONE;
                    res_hi_d = hi_d;
                    res_lo_d = lo_d;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ALU drive is registered, so it is derived from next-cycle state.
        if (state_d == RUN) begin
            if (op_d) begin
                alu_x_d   = {hi_d[30:0], lo_d[31]};
                alu_y_d   = mcand_d;
                alu_sub_d = 1'b1;
            end else begin
                alu_x_d   = hi_d;
                alu_y_d   = lo_d[0] ? mcand_d : 32'd0;
                alu_sub_d = 1'b0;
            end
        end else begin
            alu_x_d   = 32'd0;
            alu_y_d   = 32'd0;
            alu_sub_d = 1'b0;
        end

        alu_sel_d = (state_d == RUN);
        done_d    = (state_q == DONE);
        busy_d    = (state_d != IDLE) || (state_q == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            mcand_q   <= 32'd0;
            cnt_q     <= 5'd0;
            res_hi_q  <= 32'd0;
            res_lo_q  <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_sel_q <= 1'b0;
            alu_x_q   <= 32'd0;
            alu_y_q   <= 32'd0;
            alu_sub_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            cnt_q     <= cnt_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_sel_q <= alu_sel_d;
            alu_x_q   <= alu_x_d;
            alu_y_q   <= alu_y_d;
            alu_sub_q <= alu_sub_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_hi    = res_hi_q;
    assign result_lo    = res_lo_q;
    assign alu_sel      = alu_sel_q;
    assign alu_x        = alu_x_q;
    assign alu_y        = alu_y_q;
    assign alu_add_sub  = alu_sub_q;
    assign alu_logic_fn = LOGIC_FN_IDLE;
    assign alu_fn_class = FN_ARITH;

endmodule
